// File: rtl/branch_pkg.sv
// Shared types for the EX-stage branch sequencer: condition codes, FSM states, flag layout.
package branch_pkg;

    localparam int unsigned CCC_W   = 3;
    localparam int unsigned FLAGS_W = 3;

    localparam logic [CCC_W-1:0] CCC_NE = 3'b000;  // !Z
    localparam logic [CCC_W-1:0] CCC_EQ = 3'b001;  // Z
    localparam logic [CCC_W-1:0] CCC_GT = 3'b010;  // !Z & !N
    localparam logic [CCC_W-1:0] CCC_MI = 3'b011;  // N
    localparam logic [CCC_W-1:0] CCC_GE = 3'b100;  // Z | !N
    localparam logic [CCC_W-1:0] CCC_LE = 3'b101;  // N | Z
    localparam logic [CCC_W-1:0] CCC_VS = 3'b110;  // V
    localparam logic [CCC_W-1:0] CCC_AL = 3'b111;  // always

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        FLUSH      = 2'd2
    } state_e;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } flags_t;

endpackage

// File: rtl/branch_flow_ctrl_if.sv
// Handshake bundle between ALU flags, EX branch decode and fetch/pipeline control.
interface branch_flow_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    import branch_pkg::*;

    logic              alu_flag_we;
    logic              alu_n;
    logic              alu_v;
    logic              alu_z;
    logic              flag_pending;
    logic              br_valid;
    logic [CCC_W-1:0]  br_ccc;
    logic [ADDR_W-1:0] br_target;
    logic              br_ack;
    logic              br_taken;
    logic              pc_redirect;
    logic [ADDR_W-1:0] pc_redirect_addr;
    logic              flush;
    logic              stall;

    modport master (
        output alu_flag_we, alu_n, alu_v, alu_z, flag_pending,
        output br_valid, br_ccc, br_target,
        input  br_ack, br_taken, pc_redirect, pc_redirect_addr, flush, stall
    );

    modport slave (
        input  alu_flag_we, alu_n, alu_v, alu_z, flag_pending,
        input  br_valid, br_ccc, br_target,
        output br_ack, br_taken, pc_redirect, pc_redirect_addr, flush, stall
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Pure combinational condition-code evaluation against a {N,V,Z} flag set.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [CCC_W-1:0] ccc,
    input  logic             n,
    input  logic             v,
    input  logic             z,
    output logic             cond_c
);

    always_comb begin
        cond_c = 1'b0;
        case (ccc)
            CCC_NE:  cond_c = ~z;
            CCC_EQ:  cond_c = z;
            CCC_GT:  cond_c = ~z & ~n;
            CCC_MI:  cond_c = n;
            CCC_GE:  cond_c = z | ~n;
            CCC_LE:  cond_c = n | z;
            CCC_VS:  cond_c = v;
            CCC_AL:  cond_c = 1'b1;
            default: cond_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_flow_ctrl.sv
// EX-stage branch sequencer: flag register, condition resolve with stall on in-flight flags,
// PC redirect and fixed-length wrong-path flush after taken branches.
module branch_flow_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_flow_ctrl_if.slave    bus,
    output logic [FLAGS_W-1:0]   flags_q,
    output logic [CNT_W-1:0]     taken_cnt
);

    localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
    logic [FLAGS_W-1:0]  flags_d;

    flags_t              eval_flags;
    logic                cond_c;
    logic                resolvable;
    logic                do_resolve;
    logic                ack_c, taken_c, redirect_c, flush_c, stall_c;

    // Same-cycle flag writes bypass the register so the branch sees the newest flags.
    assign eval_flags = bus.alu_flag_we ? flags_t'({bus.alu_n, bus.alu_v, bus.alu_z})
                                        : flags_t'(flags_q);
    assign resolvable = bus.br_valid & (bus.alu_flag_we | ~bus.flag_pending);

    branch_cond_eval u_cond_eval (
        .ccc    (bus.br_ccc),
        .n      (eval_flags.n),
        .v      (eval_flags.v),
        .z      (eval_flags.z),
        .cond_c (cond_c)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        taken_cnt_d = taken_cnt_q;
        flags_d     = bus.alu_flag_we ? {bus.alu_n, bus.alu_v, bus.alu_z} : flags_q;
        do_resolve  = 1'b0;
        ack_c       = 1'b0;
        taken_c     = 1'b0;
        redirect_c  = 1'b0;
        flush_c     = 1'b0;
        stall_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.br_valid) begin
                    if (resolvable) begin
                        do_resolve = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = WAIT_FLAGS;
                    end
                end
            end
            WAIT_FLAGS: begin
                // A dropped br_valid means the branch was squashed upstream.
                if (!bus.br_valid) begin
                    state_d = IDLE;
                end else if (resolvable) begin
                    do_resolve = 1'b1;
                    state_d    = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            FLUSH: begin
                // Any branch seen here is wrong-path: no ack, no stall.
                flush_c = 1'b1;
                if (flush_cnt_q <= FCNT_W'(1)) begin
                    flush_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                flush_cnt_d = '0;
            end
        endcase

        if (do_resolve) begin
            ack_c   = 1'b1;
            taken_c = cond_c;
            if (cond_c) begin
                redirect_c = 1'b1;
                flush_c    = 1'b1;
                if (~&taken_cnt_q) begin
                    taken_cnt_d = taken_cnt_q + CNT_W'(1);
                end
                if (FLUSH_CYCLES > 1) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FCNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            taken_cnt_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            flags_q     <= flags_d;
        end
    end

    // Mealy outputs are forced low while reset is asserted.
    assign bus.br_ack           = rst_n & ack_c;
    assign bus.br_taken         = rst_n & taken_c;
    assign bus.pc_redirect      = rst_n & redirect_c;
    assign bus.pc_redirect_addr = (rst_n & redirect_c) ? bus.br_target : '0;
    assign bus.flush            = rst_n & flush_c;
    assign bus.stall            = rst_n & stall_c;
    assign taken_cnt            = taken_cnt_q;

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Directed scoreboard bench for branch_flow_ctrl (FLUSH_CYCLES=2, CNT_W=2 to reach saturation).
module tb_branch_flow_ctrl;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 2;

    logic clk;
    logic rst_n;
    logic [2:0]       flags_q;
    logic [CNT_W-1:0] taken_cnt;

    branch_flow_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    branch_flow_ctrl #(
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flags_q   (flags_q),
        .taken_cnt (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              ack;
        logic              tkn;
        logic              rdr;
        logic [ADDR_W-1:0] addr;
        logic              fl;
        logic              st;
        logic [2:0]        fq;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Drive one cycle of inputs just after the edge and queue the outputs expected in that cycle.
    task automatic step(input string nm, input logic rst,
                        input logic we, input logic n, input logic v, input logic z,
                        input logic pend, input logic bv, input logic [2:0] ccc,
                        input logic [ADDR_W-1:0] tgt,
                        input logic e_ack, input logic e_tkn, input logic e_rdr,
                        input logic [ADDR_W-1:0] e_addr, input logic e_fl, input logic e_st,
                        input logic [2:0] e_fq, input logic [CNT_W-1:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = rst;
        bus.alu_flag_we  = we;
        bus.alu_n        = n;
        bus.alu_v        = v;
        bus.alu_z        = z;
        bus.flag_pending = pend;
        bus.br_valid     = bv;
        bus.br_ccc       = ccc;
        bus.br_target    = tgt;
        e.name = nm; e.ack = e_ack; e.tkn = e_tkn; e.rdr = e_rdr; e.addr = e_addr;
        e.fl = e_fl; e.st = e_st; e.fq = e_fq; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [ADDR_W+9+CNT_W-1:0] act, req;
            e   = exp_q.pop_front();
            act = {bus.br_ack, bus.br_taken, bus.pc_redirect, bus.pc_redirect_addr,
                   bus.flush, bus.stall, flags_q, taken_cnt};
            req = {e.ack, e.tkn, e.rdr, e.addr, e.fl, e.st, e.fq, e.cnt};
            checks++;
            if (act === req) begin
                passed++;
            end else begin
                $display("FAIL %s: got ack=%b taken=%b redir=%b addr=%h flush=%b stall=%b flags=%b cnt=%0d ; want ack=%b taken=%b redir=%b addr=%h flush=%b stall=%b flags=%b cnt=%0d",
                         e.name, bus.br_ack, bus.br_taken, bus.pc_redirect, bus.pc_redirect_addr,
                         bus.flush, bus.stall, flags_q, taken_cnt,
                         e.ack, e.tkn, e.rdr, e.addr, e.fl, e.st, e.fq, e.cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.alu_flag_we = 1'b0; bus.alu_n = 1'b0; bus.alu_v = 1'b0; bus.alu_z = 1'b0;
        bus.flag_pending = 1'b0; bus.br_valid = 1'b0; bus.br_ccc = 3'd0; bus.br_target = '0;

        //    name        rst we n v z pend bv ccc tgt        ack tk rd addr      fl st fq      cnt
        step("rst_hold",  0, 1,1,1,1, 0, 1, 3'd7, 16'hFFFF,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        step("rst_idle",  1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        // Taken on bypassed Z, 2-cycle flush
        step("t1_res",    1, 1,0,0,1, 0, 1, 3'd1, 16'h0040,  1,1,1, 16'h0040, 1,0, 3'b000, 2'd0);
        step("t1_fl2",    1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 1,0, 3'b001, 2'd1);
        step("t1_idle",   1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b001, 2'd1);
        // Not taken from registered flags
        step("t2_wr",     1, 1,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b001, 2'd1);
        step("t2_res",    1, 0,0,0,0, 0, 1, 3'd3, 16'h0080,  1,0,0, 16'h0000, 0,0, 3'b000, 2'd1);
        // Stall on pending flags, resolve with same-cycle V
        step("t3_st1",    1, 0,0,0,0, 1, 1, 3'd6, 16'h1234,  0,0,0, 16'h0000, 0,1, 3'b000, 2'd1);
        step("t3_st2",    1, 0,0,0,0, 1, 1, 3'd6, 16'h1234,  0,0,0, 16'h0000, 0,1, 3'b000, 2'd1);
        step("t3_st3",    1, 0,0,0,0, 1, 1, 3'd6, 16'h1234,  0,0,0, 16'h0000, 0,1, 3'b000, 2'd1);
        step("t3_res",    1, 1,0,1,0, 1, 1, 3'd6, 16'h1234,  1,1,1, 16'h1234, 1,0, 3'b000, 2'd1);
        step("t3_fl2",    1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 1,0, 3'b010, 2'd2);
        // Wrong-path branch during flush is ignored; flag write still lands
        step("t4_res",    1, 0,0,0,0, 0, 1, 3'd7, 16'h00A0,  1,1,1, 16'h00A0, 1,0, 3'b010, 2'd2);
        step("t4_fl2",    1, 1,1,0,1, 0, 1, 3'd7, 16'h00B0,  0,0,0, 16'h0000, 1,0, 3'b010, 2'd3);
        step("t4_idle",   1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b101, 2'd3);
        // Branch dropped while waiting: no ack
        step("wd_st",     1, 0,0,0,0, 1, 1, 3'd0, 16'h0010,  0,0,0, 16'h0000, 0,1, 3'b101, 2'd3);
        step("wd_drop",   1, 0,0,0,0, 1, 0, 3'd0, 16'h0010,  0,0,0, 16'h0000, 0,0, 3'b101, 2'd3);
        step("wd_idle",   1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b101, 2'd3);
        step("nt_ne",     1, 0,0,0,0, 0, 1, 3'd0, 16'h0020,  1,0,0, 16'h0000, 0,0, 3'b101, 2'd3);
        // Reset in first flush cycle
        step("t5_res",    1, 0,0,0,0, 0, 1, 3'd7, 16'h0200,  1,1,1, 16'h0200, 1,0, 3'b101, 2'd3);
        step("t5_rst",    0, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        step("t5_rel",    1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        step("t5_idle",   1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        // Reset while waiting for flags
        step("w5_st",     1, 0,0,0,0, 1, 1, 3'd7, 16'h0400,  0,0,0, 16'h0000, 0,1, 3'b000, 2'd0);
        step("w5_rst",    0, 0,0,0,0, 1, 1, 3'd7, 16'h0400,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        step("w5_rel",    1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        step("nt_le",     1, 0,0,0,0, 0, 1, 3'd5, 16'h0500,  1,0,0, 16'h0000, 0,0, 3'b000, 2'd0);
        // Four taken branches with different codes: counter saturates at 3
        step("t6_a",      1, 0,0,0,0, 0, 1, 3'd0, 16'h0300,  1,1,1, 16'h0300, 1,0, 3'b000, 2'd0);
        step("t6_af",     1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 1,0, 3'b000, 2'd1);
        step("t6_b",      1, 0,0,0,0, 0, 1, 3'd2, 16'h0304,  1,1,1, 16'h0304, 1,0, 3'b000, 2'd1);
        step("t6_bf",     1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 1,0, 3'b000, 2'd2);
        step("t6_c",      1, 0,0,0,0, 0, 1, 3'd4, 16'h0308,  1,1,1, 16'h0308, 1,0, 3'b000, 2'd2);
        step("t6_cf",     1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 1,0, 3'b000, 2'd3);
        step("t6_d",      1, 0,0,0,0, 0, 1, 3'd7, 16'h030C,  1,1,1, 16'h030C, 1,0, 3'b000, 2'd3);
        step("t6_df",     1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 1,0, 3'b000, 2'd3);
        step("t6_idle",   1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b000, 2'd3);
        // Bypassed Z makes !Z fail in the same cycle
        step("byp_res",   1, 1,0,0,1, 0, 1, 3'd0, 16'h0600,  1,0,0, 16'h0000, 0,0, 3'b000, 2'd3);
        step("byp_after", 1, 0,0,0,0, 0, 0, 3'd0, 16'h0000,  0,0,0, 16'h0000, 0,0, 3'b001, 2'd3);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
